// File: rtl/bsg_tx_feeder_if.sv
// Register-write bus between the transmit feeder (master) and the BSG core (slave).
// A write completes on the cycle where bsg_valid and bsg_ready are both high.
interface bsg_tx_feeder_if;
  logic [7:0] bsg_addr;
  logic [7:0] bsg_data;
  logic       bsg_valid;
  logic       bsg_ready;

  modport master (
    output bsg_addr,
    output bsg_data,
    output bsg_valid,
    input  bsg_ready
  );

  modport slave (
    input  bsg_addr,
    input  bsg_data,
    input  bsg_valid,
    output bsg_ready
  );
endinterface

// File: rtl/bsg_tx_feeder.sv
// Byte FIFO feeding the BSG transmitter: each pair is sent as DATA_0, DATA_1 and CONTROL=GO,
// then the feeder waits for BSG_INT (or a timeout) and acknowledges by clearing CONTROL.
module bsg_tx_feeder #(
  parameter int unsigned DEPTH      = 16,
  parameter logic [7:0]  ADDR_CTRL  = 8'h00,
  parameter logic [7:0]  ADDR_DATA0 = 8'h01,
  parameter logic [7:0]  ADDR_DATA1 = 8'h02,
  parameter logic [7:0]  PAD_BYTE   = 8'h00,
  parameter int unsigned PAD_WAIT   = 64,
  parameter int unsigned INT_WAIT   = 4096
) (
  input  logic                   SYS_CLK,
  input  logic                   SYS_RST,
  input  logic                   push,
  input  logic [7:0]             push_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level,
  bsg_tx_feeder_if.master        bsg,
  input  logic                   bsg_int,
  output logic                   busy,
  output logic                   err_to,
  output logic [7:0]             pairs_sent
);

  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned LVL_W   = PTR_W + 1;
  localparam int unsigned CNT_MAX = (PAD_WAIT > INT_WAIT) ? PAD_WAIT : INT_WAIT;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [7:0]  CTRL_GO  = 8'h03;
  localparam logic [7:0]  CTRL_ACK = 8'h00;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD0,
    S_LOAD1,
    S_START,
    S_WAIT_INT,
    S_ACK
  } state_e;

  // FIFO storage and occupancy
  logic [7:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0] level_q, level_d;
  logic             full_q, empty_q;
  logic             do_push, pop;
  logic [7:0]       head;

  // FSM and bus registers
  state_e           state_q, state_d;
  logic             valid_q, valid_d;
  logic [7:0]       addr_q, addr_d;
  logic [7:0]       data_q, data_d;
  logic             pad_q, pad_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [7:0]       pairs_q, pairs_d;
  logic             busy_q;
  logic             xfer;

  assign do_push = push && !full_q;
  assign head    = mem_q[rd_ptr_q];
  assign xfer    = valid_q && bsg.bsg_ready;

  always_comb begin
    level_d = level_q;
    if (do_push && !pop) begin
      level_d = level_q + LVL_W'(1);
    end else if (!do_push && pop) begin
      level_d = level_q - LVL_W'(1);
    end
  end

  always_ff @(posedge SYS_CLK) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  always_ff @(posedge SYS_CLK) begin
    if (SYS_RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      level_q <= level_d;
      full_q  <= (level_d == LVL_W'(DEPTH));
      empty_q <= (level_d == '0);
    end
  end

  // Each state issues its write once valid is low; a pending write holds until ready.
  always_comb begin
    state_d = state_q;
    valid_d = valid_q && !bsg.bsg_ready;
    addr_d  = addr_q;
    data_d  = data_q;
    pad_d   = pad_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    pairs_d = pairs_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty_q) begin
          state_d = S_LOAD0;
          valid_d = 1'b1;
          addr_d  = ADDR_DATA0;
          data_d  = head;
        end
      end
      S_LOAD0: begin
        if (xfer) begin
          pop     = 1'b1;
          state_d = S_LOAD1;
          cnt_d   = '0;
        end
      end
      S_LOAD1: begin
        if (xfer) begin
          pop     = !pad_q;
          state_d = S_START;
        end else if (!valid_q) begin
          if (!empty_q) begin
            valid_d = 1'b1;
            addr_d  = ADDR_DATA1;
            data_d  = head;
            pad_d   = 1'b0;
            cnt_d   = '0;
          end else if (cnt_q >= CNT_W'(PAD_WAIT - 1)) begin
            valid_d = 1'b1;
            addr_d  = ADDR_DATA1;
            data_d  = PAD_BYTE;
            pad_d   = 1'b1;
            cnt_d   = CNT_W'(PAD_WAIT);
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_START: begin
        if (xfer) begin
          state_d = S_WAIT_INT;
          cnt_d   = '0;
        end else if (!valid_q) begin
          valid_d = 1'b1;
          addr_d  = ADDR_CTRL;
          data_d  = CTRL_GO;
        end
      end
      S_WAIT_INT: begin
        if (bsg_int) begin
          state_d = S_ACK;
        end else if (cnt_q >= CNT_W'(INT_WAIT - 1)) begin
          err_d   = 1'b1;
          cnt_d   = CNT_W'(INT_WAIT);
          state_d = S_ACK;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_ACK: begin
        if (xfer) begin
          pairs_d = pairs_q + 8'd1;
          state_d = S_IDLE;
        end else if (!valid_q) begin
          valid_d = 1'b1;
          addr_d  = ADDR_CTRL;
          data_d  = CTRL_ACK;
        end
      end
      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge SYS_CLK) begin
    if (SYS_RST) begin
      state_q <= S_IDLE;
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      pad_q   <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      pairs_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      pad_q   <= pad_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      pairs_q <= pairs_d;
      busy_q  <= (state_d != S_IDLE);
    end
  end

  assign full          = full_q;
  assign empty         = empty_q;
  assign level         = level_q;
  assign bsg.bsg_valid = valid_q;
  assign bsg.bsg_addr  = addr_q;
  assign bsg.bsg_data  = data_q;
  assign busy          = busy_q;
  assign err_to        = err_q;
  assign pairs_sent    = pairs_q;

endmodule
